// File: rtl/sfx_pkg.sv
// Shared definitions for the sound-effect scheduler: FSM encoding, tone ROM
// entry layout and field helpers, source indices and a default effect table.
package sfx_pkg;

  localparam int unsigned PER_W   = 16;
  localparam int unsigned DUR_W   = 10;
  localparam int unsigned ENTRY_W = PER_W + DUR_W;

  localparam int unsigned SFX_PADDLE = 0;
  localparam int unsigned SFX_WALL   = 1;
  localparam int unsigned SFX_BRICK  = 2;
  localparam int unsigned SFX_LIFE   = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2,
    ST_NEXT = 2'd3
  } sfx_state_t;

  function automatic logic [PER_W-1:0] entry_period(input logic [ENTRY_W-1:0] e);
    return e[PER_W-1:0];
  endfunction

  function automatic logic [DUR_W-1:0] entry_dur(input logic [ENTRY_W-1:0] e);
    return e[ENTRY_W-1:PER_W];
  endfunction

  // Default 4x4 table at 50 MHz, highest address first; entry = {dur, half_period}.
  localparam logic [16*ENTRY_W-1:0] SFX_ROM_DEFAULT = {
    {10'd300, 16'd63131}, {10'd150, 16'd50000}, {10'd150, 16'd37879}, {10'd150, 16'd28409},
    {10'd0,   16'd0},     {10'd0,   16'd0},     {10'd25,  16'd18939}, {10'd25,  16'd28409},
    {10'd0,   16'd0},     {10'd0,   16'd0},     {10'd0,   16'd0},     {10'd30,  16'd37879},
    {10'd0,   16'd0},     {10'd0,   16'd0},     {10'd0,   16'd0},     {10'd40,  16'd56818}
  };

endpackage

// File: rtl/sfx_tick_divider.sv
// Free-running duration tick: TICK is high for one cycle every TICK_DIV
// cycles, with the phase realigned by RESTART.
module sfx_tick_divider #(
  parameter int unsigned TICK_DIV = 48828
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic RESTART,
  output logic TICK
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (RESTART || cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign TICK = (cnt_q == LAST);

endmodule

// File: rtl/sfx_scheduler.sv
// Fixed-priority sound-effect arbiter and note sequencer driving the square
// synth's half period and enable from a parameter-initialised tone ROM.
module sfx_scheduler
  import sfx_pkg::*;
#(
  parameter int unsigned NUM_SRC  = 4,
  parameter int unsigned NOTES    = 4,
  parameter int unsigned TICK_DIV = 48828,
  parameter logic [NUM_SRC*NOTES*ENTRY_W-1:0] ROM_INIT = SFX_ROM_DEFAULT
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  input  logic [NUM_SRC-1:0]         REQ,
  output logic [NUM_SRC-1:0]         ACK,
  output logic [PER_W-1:0]           HALF_PERIOD,
  output logic                       SYNTH_EN,
  output logic                       BUSY,
  output logic [$clog2(NUM_SRC)-1:0] ACTIVE_ID
);

  localparam int unsigned IDW = $clog2(NUM_SRC);
  localparam int unsigned SW  = $clog2(NOTES);

  sfx_state_t         state_q, state_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] ack_q, ack_d;
  logic [IDW-1:0]     active_q, active_d;
  logic [SW-1:0]      step_q, step_d;
  logic [PER_W-1:0]   half_q, half_d;
  logic               en_q, en_d;
  logic [DUR_W-1:0]   dcnt_q, dcnt_d;
  logic [DUR_W-1:0]   dur_q, dur_d;

  logic [ENTRY_W-1:0] rom_entry;
  logic [IDW-1:0]     top_idx;
  logic               any_pend;
  logic               grant;
  logic               restart;
  logic               tick;

  sfx_tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .RESTART (restart),
    .TICK    (tick)
  );

  always_comb begin
    rom_entry = ROM_INIT[(32'(active_q) * NOTES + 32'(step_q)) * ENTRY_W +: ENTRY_W];
  end

  always_comb begin
    top_idx  = '0;
    any_pend = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (pend_q[i]) begin
        top_idx  = IDW'(i);
        any_pend = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    ack_d    = '0;
    active_d = active_q;
    step_d   = step_q;
    half_d   = half_q;
    en_d     = en_q;
    dcnt_d   = dcnt_q;
    dur_d    = dur_q;
    restart  = 1'b0;
    grant    = any_pend && (state_q == ST_IDLE || top_idx > active_q);

    if (grant) begin
      // A grant (fresh or preempting) overrides the sequencer; outputs hold until the next LOAD.
      state_d         = ST_LOAD;
      active_d        = top_idx;
      step_d          = '0;
      ack_d[top_idx]  = 1'b1;
      pend_d[top_idx] = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          restart = 1'b1;
          dcnt_d  = '0;
          if (entry_dur(rom_entry) == '0 && step_q != '0) begin
            state_d = ST_IDLE;
            en_d    = 1'b0;
          end else begin
            state_d = ST_PLAY;
            half_d  = entry_period(rom_entry);
            dur_d   = entry_dur(rom_entry);
            en_d    = (entry_period(rom_entry) != '0) && (entry_dur(rom_entry) != '0);
          end
        end
        ST_PLAY: begin
          if (dur_q == '0) begin
            state_d = ST_NEXT;
          end else if (tick) begin
            dcnt_d = dcnt_q + 1'b1;
            if (dcnt_d == dur_q) begin
              state_d = ST_NEXT;
            end
          end
        end
        ST_NEXT: begin
          if (step_q == SW'(NOTES - 1)) begin
            state_d = ST_IDLE;
            en_d    = 1'b0;
          end else begin
            step_d  = step_q + 1'b1;
            state_d = ST_LOAD;
          end
        end
        default: ;
      endcase
    end

    pend_d = pend_d | REQ;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= ST_IDLE;
      pend_q   <= '0;
      ack_q    <= '0;
      active_q <= '0;
      step_q   <= '0;
      half_q   <= '0;
      en_q     <= 1'b0;
      dcnt_q   <= '0;
      dur_q    <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      ack_q    <= ack_d;
      active_q <= active_d;
      step_q   <= step_d;
      half_q   <= half_d;
      en_q     <= en_d;
      dcnt_q   <= dcnt_d;
      dur_q    <= dur_d;
    end
  end

  assign ACK         = ack_q;
  assign HALF_PERIOD = half_q;
  assign SYNTH_EN    = en_q;
  assign BUSY        = (state_q != ST_IDLE);
  assign ACTIVE_ID   = active_q;

endmodule

// File: tb/tb_sfx_scheduler.sv
// Directed bench for sfx_scheduler with TICK_DIV=4 and a small hand-built tone table.
module tb_sfx_scheduler;

  // Entry = {dur, half_period}, highest address first.
  localparam logic [16*26-1:0] TB_ROM = {
    26'd0,            26'd0,            {10'd5, 16'd800}, {10'd5, 16'd900},
    26'd0,            26'd0,            26'd0,            {10'd2, 16'd500},
    {10'd1, 16'd330}, {10'd1, 16'd320}, {10'd1, 16'd310}, {10'd1, 16'd300},
    26'd0,            26'd0,            {10'd2, 16'd0},   {10'd3, 16'd100}
  };

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [3:0]  REQ;
  logic [3:0]  ACK;
  logic [15:0] HALF_PERIOD;
  logic        SYNTH_EN;
  logic        BUSY;
  logic [1:0]  ACTIVE_ID;

  int checks   = 0;
  int failures = 0;
  int t        = 0;
  int acks     = 0;

  sfx_scheduler #(
    .NUM_SRC  (4),
    .NOTES    (4),
    .TICK_DIV (4),
    .ROM_INIT (TB_ROM)
  ) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .REQ         (REQ),
    .ACK         (ACK),
    .HALF_PERIOD (HALF_PERIOD),
    .SYNTH_EN    (SYNTH_EN),
    .BUSY        (BUSY),
    .ACTIVE_ID   (ACTIVE_ID)
  );

  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
    t++;
  endtask

  task automatic go(input int n);
    while (t < n) cyc();
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s t=%0d observed=%0d expected=%0d", tag, t, got, exp);
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (BUSY !== 1'b0 && n < budget) begin
      cyc();
      n++;
    end
    chk(tag, 32'(BUSY), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0d observed=timeout expected=finish", t);
    $fatal(1, "watchdog expired");
  end

  initial begin
    RESET_N = 1'b0;
    REQ     = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ack",  32'(ACK), 0);
    chk("rst_half", 32'(HALF_PERIOD), 0);
    chk("rst_en",   32'(SYNTH_EN), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_id",   32'(ACTIVE_ID), 0);
    RESET_N = 1'b1;
    cyc(); cyc();
    chk("idle_busy", 32'(BUSY), 0);
    chk("idle_ack",  32'(ACK), 0);

    // Paddle effect: 12-cycle tone, 2-cycle gap, 8-cycle rest, ends on a dur==0 entry.
    t = 0; REQ = 4'b0001; cyc(); REQ = '0;
    go(1);  chk("t2_noack1", 32'(ACK), 0);
    go(2);  chk("t2_ack", 32'(ACK), 1); chk("t2_busy2", 32'(BUSY), 1);
            chk("t2_en2", 32'(SYNTH_EN), 0); chk("t2_id", 32'(ACTIVE_ID), 0);
    go(3);  chk("t2_half3", 32'(HALF_PERIOD), 100); chk("t2_en3", 32'(SYNTH_EN), 1);
            chk("t2_ack3", 32'(ACK), 0);
    go(14); chk("t2_en14", 32'(SYNTH_EN), 1);
    go(16); chk("t2_half16", 32'(HALF_PERIOD), 100); chk("t2_en16", 32'(SYNTH_EN), 1);
    go(17); chk("t2_half17", 32'(HALF_PERIOD), 0); chk("t2_en17", 32'(SYNTH_EN), 0);
    go(26); chk("t2_busy26", 32'(BUSY), 1);
    go(27); chk("t2_busy27", 32'(BUSY), 0); chk("t2_en27", 32'(SYNTH_EN), 0);
    go(30); chk("t2_idle30", 32'(BUSY), 0);

    // Life-lost preempts paddle mid-note; paddle is not resumed.
    t = 0; REQ = 4'b0001; cyc(); REQ = '0;
    go(5); REQ = 4'b1000; cyc(); REQ = '0;
    chk("t3_ack6", 32'(ACK), 0); chk("t3_half6", 32'(HALF_PERIOD), 100);
    go(7);  chk("t3_ack", 32'(ACK), 8); chk("t3_id", 32'(ACTIVE_ID), 3);
            chk("t3_half7", 32'(HALF_PERIOD), 100); chk("t3_en7", 32'(SYNTH_EN), 1);
    go(8);  chk("t3_half8", 32'(HALF_PERIOD), 900);
    go(27); chk("t3_half27", 32'(HALF_PERIOD), 900);
    go(29); chk("t3_half29", 32'(HALF_PERIOD), 900);
    go(30); chk("t3_half30", 32'(HALF_PERIOD), 800);
    go(51); chk("t3_busy51", 32'(BUSY), 1);
    go(52);
    while (t < 56) begin
      chk("t3_noresume_busy", 32'(BUSY), 0);
      chk("t3_noresume_ack", 32'(ACK), 0);
      cyc();
    end

    // Wall request during life-lost waits; granted the cycle after IDLE.
    t = 0; REQ = 4'b1000; cyc(); REQ = '0;
    go(2);  chk("t4_ack3", 32'(ACK), 8);
    go(3);  chk("t4_half3", 32'(HALF_PERIOD), 900);
    go(10); REQ = 4'b0010; cyc(); REQ = '0;
    while (t < 47) begin
      chk("t4_wait_ack", 32'(ACK), 0);
      cyc();
    end
    chk("t4_busy47", 32'(BUSY), 0); chk("t4_ack47", 32'(ACK), 0);
    go(48); chk("t4_ack1", 32'(ACK), 2); chk("t4_id", 32'(ACTIVE_ID), 1);
    go(49); chk("t4_half49", 32'(HALF_PERIOD), 300); chk("t4_en49", 32'(SYNTH_EN), 1);
    go(55); chk("t4_half55", 32'(HALF_PERIOD), 310);
    go(67); chk("t4_half67", 32'(HALF_PERIOD), 330);
    go(71); chk("t4_busy71", 32'(BUSY), 1); chk("t4_en71", 32'(SYNTH_EN), 1);
    go(72); chk("t4_busy72", 32'(BUSY), 0); chk("t4_en72", 32'(SYNTH_EN), 0);
            chk("t4_hold72", 32'(HALF_PERIOD), 330);

    // Simultaneous brick and paddle: brick first, paddle after.
    t = 0; REQ = 4'b0101; cyc(); REQ = '0;
    go(2); chk("t5_ack2", 32'(ACK), 4); chk("t5_id2", 32'(ACTIVE_ID), 2);
    go(3); chk("t5_half3", 32'(HALF_PERIOD), 500);
    while (t < 13) begin
      chk("t5_wait_ack", 32'(ACK), 0);
      cyc();
    end
    chk("t5_busy13", 32'(BUSY), 0);
    go(14); chk("t5_ack14", 32'(ACK), 1); chk("t5_id14", 32'(ACTIVE_ID), 0);
    wait_idle("t5_idle", 40);
    cyc(); cyc(); cyc();
    chk("t5_empty", 32'(BUSY), 0);

    // Brick re-requested while playing replays back to back.
    t = 0; REQ = 4'b0100; cyc(); REQ = '0;
    go(2); chk("t6_ack2", 32'(ACK), 4);
    acks = (ACK != '0) ? 1 : 0;
    go(5); REQ = 4'b0100; cyc(); REQ = '0;
    while (t < 30) begin
      cyc();
      if (ACK != '0) acks++;
      if (t == 14) chk("t6_ack14", 32'(ACK), 4);
    end
    chk("t6_ack_count", 32'(acks), 2);
    chk("t6_busy30", 32'(BUSY), 0);

    // Asynchronous reset mid-note with a request pending.
    t = 0; REQ = 4'b1000; cyc(); REQ = '0;
    go(5); REQ = 4'b0010; cyc(); REQ = '0;
    go(10); chk("t1_play_en", 32'(SYNTH_EN), 1); chk("t1_play_half", 32'(HALF_PERIOD), 900);
    RESET_N = 1'b0;
    #2;
    chk("t1_ack",  32'(ACK), 0);
    chk("t1_half", 32'(HALF_PERIOD), 0);
    chk("t1_en",   32'(SYNTH_EN), 0);
    chk("t1_busy", 32'(BUSY), 0);
    chk("t1_id",   32'(ACTIVE_ID), 0);
    cyc(); cyc();
    RESET_N = 1'b1;
    repeat (6) begin
      cyc();
      chk("t1_post_busy", 32'(BUSY), 0);
      chk("t1_post_ack", 32'(ACK), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
